// File: rtl/receive.sv
// receive: 8N1 asynchronous serial receiver with a stb/ack output holding register.
// The rxd line goes through a two-flop synchronizer. A single FSM times the
// start-bit midpoint, eight data bits and the stop bit. Delivered bytes are
// held on dat with stb until ack is seen. An unread byte is never overwritten:
// a new byte that arrives while stb is still set is dropped and ovr pulses.
// Optional build macro: RECEIVE_FILTER_EN. When it is defined, each sample
// point takes the majority of the last three synchronized rxd values.
module receive #(
   parameter int BAUD = 9600,
   parameter int FREQ = 12000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   input  logic       ack,
   output logic       stb,
   output logic [7:0] dat,
   output logic       err,
   output logic       ovr
);

   localparam int PERIOD = FREQ / BAUD;
   localparam int HALF   = PERIOD / 2;
   localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    idx_reg;
   logic [7:0]    shf_reg;
   logic [1:0]    sync_reg;
   logic          rs;
   logic          smp;

   assign rs = sync_reg[1];

   // Two-flop synchronizer. It resets to the idle-high line level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rxd};
      end
   end

`ifdef RECEIVE_FILTER_EN
   logic [1:0] hist_reg;

   // History of the two previous rs values, used for the 2-of-3 majority vote.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_reg <= 2'b11;
      end else begin
         hist_reg <= {hist_reg[0], rs};
      end
   end

   assign smp = (rs & hist_reg[0]) | (rs & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
`else
   assign smp = rs;
`endif

   // Frame FSM plus output holding register. All outputs are registered here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shf_reg   <= '0;
         stb       <= 1'b0;
         dat       <= '0;
         err       <= 1'b0;
         ovr       <= 1'b0;
      end else begin
         err <= 1'b0;
         ovr <= 1'b0;

         // A consumed byte clears stb. A delivery in the same cycle sets it again below.
         if (stb && ack) begin
            stb <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               idx_reg <= '0;
               if (!rs) begin
                  state_reg <= START;
               end
            end

            START: begin
               if (cnt_reg == CNT_HALF) begin
                  cnt_reg <= '0;
                  // A high sample at mid-start means the low level was a glitch.
                  state_reg <= smp ? IDLE : DATA;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end

            DATA: begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_reg          <= '0;
                  shf_reg[idx_reg] <= smp;
                  idx_reg          <= idx_reg + 3'd1;
                  if (idx_reg == 3'd7) begin
                     state_reg <= STOP;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end

            STOP: begin
               if (cnt_reg == CNT_LAST) begin
                  cnt_reg <= '0;
                  if (smp) begin
                     if (!stb || ack) begin
                        dat <= shf_reg;
                        stb <= 1'b1;
                     end else begin
                        ovr <= 1'b1;
                     end
                     state_reg <= IDLE;
                  end else begin
                     err       <= 1'b1;
                     state_reg <= BREAK;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end

            BREAK: begin
               // Wait out a held-low line so that it produces only one err.
               cnt_reg <= '0;
               if (rs) begin
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               idx_reg   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_receive.sv
// tb_receive: scoreboard bench for receive with BAUD=1 and FREQ=16 (PERIOD=16, HALF=8).
// A monitor on the falling edge pops expected bytes whenever a delivery occurs.
// It also counts the err and ovr pulses.
module tb_receive;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic       ack;
   logic       stb;
   logic [7:0] dat;
   logic       err;
   logic       ovr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int dlv_cnt = 0;
   int err_cnt = 0;
   int ovr_cnt = 0;
   int last_dlv_cyc = -1;
   int frame_start  = 0;

   logic [7:0] exp_q[$];
   logic       prev_stb = 1'b0;
   logic       prev_ack = 1'b0;

   receive #(.BAUD(1), .FREQ(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .rxd  (rxd),
      .ack  (ack),
      .stb  (stb),
      .dat  (dat),
      .err  (err),
      .ovr  (ovr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor. A delivery is stb high after an edge at which stb was
   // low, or after an edge at which stb and ack were both high.
   always @(negedge clk) begin
      logic [7:0] e;
      if (stb === 1'b1 && (prev_stb !== 1'b1 || prev_ack === 1'b1)) begin
         dlv_cnt++;
         last_dlv_cyc = cyc;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got dat=%02h at cycle %0d, required no delivery", dat, cyc);
         end else begin
            e = exp_q.pop_front();
            if (dat !== e) begin
               bad++;
               $display("FAIL sb_dat: got %02h, required %02h", dat, e);
            end else begin
               $display("delivery: dat=%02h cycle=%0d", dat, cyc);
            end
         end
      end
      if (err === 1'b1) err_cnt++;
      if (ovr === 1'b1) ovr_cnt++;
      if (err === 1'b1 && ovr === 1'b1) begin
         total++;
         bad++;
         $display("FAIL err_ovr_overlap: err=%b ovr=%b, required not both", err, ovr);
      end
      prev_stb = stb;
      prev_ack = ack;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one 8N1 frame. Each value is set 1 time unit after an edge and is
   // first sampled at the following edge.
   task automatic send_frame(input logic [7:0] b, input bit glitch,
                             input int stop_low, input int rst_bit);
      rxd = 1'b0;
      frame_start = cyc + 1;
      step(16);
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 16; j++) begin
            rxd = b[i] ^ (glitch && j == 8);
            if (i == rst_bit && j == 0) rst_n = 1'b0;
            else if (i == rst_bit && j == 1) rst_n = 1'b1;
            step(1);
         end
      end
      if (stop_low > 0) begin
         rxd = 1'b0;
         step(stop_low);
         rxd = 1'b1;
      end else begin
         rxd = 1'b1;
         step(16);
      end
      $display("frame: byte=%02h glitch=%0d stop_low=%0d rst_bit=%0d", b, glitch, stop_low, rst_bit);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rxd   = 1'b1;
      ack   = 1'b1;
      step(3);
      total += 4;
      if (stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b, required 0", stb); end
      if (dat !== 8'h00) begin bad++; $display("FAIL reset_dat: got %02h, required 00", dat); end
      if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b, required 0", err); end
      if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b, required 0", ovr); end
      rst_n = 1'b1;
      step(5);
   endtask

   task automatic test_single();
      int d0, e0, o0;
      d0 = dlv_cnt; e0 = err_cnt; o0 = ovr_cnt;
      ack = 1'b1;
      last_dlv_cyc = -1;
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b0, 0, -1);
      step(4);
      total += 5;
      if (last_dlv_cyc - frame_start !== 154) begin
         bad++;
         $display("FAIL single_latency: got %0d, required 154", last_dlv_cyc - frame_start);
      end
      if (dlv_cnt - d0 !== 1) begin bad++; $display("FAIL single_dlv: got %0d, required 1", dlv_cnt - d0); end
      if (err_cnt - e0 !== 0) begin bad++; $display("FAIL single_err: got %0d, required 0", err_cnt - e0); end
      if (ovr_cnt - o0 !== 0) begin bad++; $display("FAIL single_ovr: got %0d, required 0", ovr_cnt - o0); end
      if (stb !== 1'b0) begin bad++; $display("FAIL single_stb_clear: got %b, required 0", stb); end
   endtask

   task automatic test_back_to_back();
      int d0, o0;
      d0 = dlv_cnt; o0 = ovr_cnt;
      ack = 1'b0;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 0, -1);
      send_frame(8'h3C, 1'b0, 0, -1);
      step(4);
      total += 4;
      if (stb !== 1'b1) begin bad++; $display("FAIL b2b_stb: got %b, required 1", stb); end
      if (dat !== 8'hA5) begin bad++; $display("FAIL b2b_dat: got %02h, required a5", dat); end
      if (ovr_cnt - o0 !== 1) begin bad++; $display("FAIL b2b_ovr: got %0d, required 1", ovr_cnt - o0); end
      if (dlv_cnt - d0 !== 1) begin bad++; $display("FAIL b2b_dlv: got %0d, required 1", dlv_cnt - d0); end
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      total += 2;
      if (stb !== 1'b0) begin bad++; $display("FAIL b2b_ack_stb: got %b, required 0", stb); end
      if (dat !== 8'hA5) begin bad++; $display("FAIL b2b_ack_dat: got %02h, required a5", dat); end
      step(2);
      ack = 1'b1;
   endtask

   task automatic test_framing_error();
      int d0, e0;
      d0 = dlv_cnt; e0 = err_cnt;
      ack = 1'b1;
      send_frame(8'h81, 1'b0, 40, -1);
      step(20);
      total += 2;
      if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_err: got %0d, required 1", err_cnt - e0); end
      if (dlv_cnt - d0 !== 0) begin bad++; $display("FAIL ferr_dlv: got %0d, required 0", dlv_cnt - d0); end
      d0 = dlv_cnt;
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 0, -1);
      step(4);
      total += 1;
      if (dlv_cnt - d0 !== 1) begin bad++; $display("FAIL ferr_recover: got %0d, required 1", dlv_cnt - d0); end
   endtask

   task automatic test_start_glitch();
      int d0, e0;
      d0 = dlv_cnt; e0 = err_cnt;
      rxd = 1'b0;
      step(4);
      rxd = 1'b1;
      step(30);
      total += 3;
      if (dlv_cnt - d0 !== 0) begin bad++; $display("FAIL sglitch_dlv: got %0d, required 0", dlv_cnt - d0); end
      if (err_cnt - e0 !== 0) begin bad++; $display("FAIL sglitch_err: got %0d, required 0", err_cnt - e0); end
      if (stb !== 1'b0) begin bad++; $display("FAIL sglitch_stb: got %b, required 0", stb); end
   endtask

   task automatic test_reset_midframe();
      int d0, e0;
      d0 = dlv_cnt; e0 = err_cnt;
      send_frame(8'hFF, 1'b0, 0, 4);
      step(20);
      total += 2;
      if (dlv_cnt - d0 !== 0) begin bad++; $display("FAIL rstmid_dlv: got %0d, required 0", dlv_cnt - d0); end
      if (err_cnt - e0 !== 0) begin bad++; $display("FAIL rstmid_err: got %0d, required 0", err_cnt - e0); end
      d0 = dlv_cnt;
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b0, 0, -1);
      step(4);
      total += 2;
      if (dlv_cnt - d0 !== 1) begin bad++; $display("FAIL rstmid_next_dlv: got %0d, required 1", dlv_cnt - d0); end
      if (dat !== 8'h12) begin bad++; $display("FAIL rstmid_next_dat: got %02h, required 12", dat); end
   endtask

   task automatic test_filter();
      logic [7:0] want;
      int d0;
`ifdef RECEIVE_FILTER_EN
      want = 8'h00;
`else
      want = 8'hFF;
`endif
      d0 = dlv_cnt;
      exp_q.push_back(want);
      send_frame(8'h00, 1'b1, 0, -1);
      step(4);
      total += 2;
      if (dlv_cnt - d0 !== 1) begin bad++; $display("FAIL filter_dlv: got %0d, required 1", dlv_cnt - d0); end
      if (dat !== want) begin bad++; $display("FAIL filter_dat: got %02h, required %02h", dat, want); end
   endtask

   initial begin
      rst_n = 1'b0;
      rxd   = 1'b1;
      ack   = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_framing_error();
      test_start_glitch();
      test_reset_midframe();
      test_filter();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/receive.md
RECEIVE -- requirements
Module: receive

Interface
REQ-001 SHALL have parameter BAUD, default 9600, line bit rate in bits/s.
REQ-002 SHALL have parameter FREQ, default 12000000, clk frequency in Hz.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-006 SHALL have port ack  input  1  downstream consumed dat this cycle.
REQ-007 SHALL have port stb  output  1  dat holds a valid received byte.
REQ-008 SHALL have port dat  output  8  received byte.
REQ-009 SHALL have port err  output  1  one-cycle framing-error pulse.
REQ-010 SHALL have port ovr  output  1  one-cycle overrun pulse.

Function
REQ-011 SHALL derive PERIOD = FREQ/BAUD (integer division) and HALF = PERIOD/2; counter width $clog2(PERIOD).
REQ-012 SHALL pass rxd through a two-flop synchronizer; all decisions use the synchronized value rs (2-cycle latency).
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: cnt=0, idx=0; on rs==0 -> START.
REQ-015 START: at cnt==HALF-1 sample; sample 1 -> IDLE (glitch, no output); sample 0 -> DATA, cnt=0.
REQ-016 DATA: at cnt==PERIOD-1 shift sample into bit idx (LSB first), cnt=0, idx+1; after 8th bit -> STOP.
REQ-017 STOP: at cnt==PERIOD-1 sample; 1 -> deliver byte, -> IDLE; 0 -> err=1 for one cycle, byte discarded, -> BREAK.
REQ-018 BREAK: remain until rs==1, then -> IDLE; a low line held indefinitely produces exactly one err.
REQ-019 Deliver: if stb==0 or ack==1 that cycle, dat<=byte and stb<=1 next cycle.
REQ-020 Deliver with stb==1 and ack==0: dat and stb unchanged, byte dropped, ovr=1 for one cycle.
REQ-021 ack with stb==1 and no delivery: stb<=0 next cycle, dat held; ack with stb==0 ignored.
REQ-022 err and ovr SHALL never both assert in the same cycle; counters never wrap past PERIOD-1.

Reset
REQ-023 rst_n==0 at a clock edge SHALL force state IDLE, cnt=0, idx=0, stb=0, dat=0, err=0, ovr=0, synchronizer flops=1.
REQ-024 Reset mid-frame SHALL abandon the frame with no stb/err; after release a still-low rxd starts a new frame from START.

Configuration
REQ-025 Macro RECEIVE_FILTER_EN defined: every sample point (START, DATA, STOP) SHALL use majority of the last three rs values.
REQ-026 RECEIVE_FILTER_EN undefined: every sample point SHALL use the single current rs; no extra state flops.
REQ-027 Macro SHALL NOT change latency, state sequencing, or port list.

Verification (BAUD=1, FREQ=16: PERIOD=16, HALF=8)
REQ-028 Frame 0x55, ack tied 1 -> stb one cycle, dat=0x55, err=0, ovr=0; stb rises after stop sample, 2+8+16*9 cycles after start edge.
REQ-029 Frames 0xA5 then 0x3C back-to-back, ack=0 -> stb=1 dat=0xA5 held, ovr pulses once on second frame, dat stays 0xA5.
REQ-030 Frame 0x81 with stop bit driven 0 for 40 cycles -> err one pulse, no stb, no second err, IDLE after rxd returns 1.
REQ-031 rxd low for 4 cycles then high -> START aborts to IDLE, no stb/err.
REQ-032 rst_n low for 1 cycle during bit 4 of frame 0xFF -> no stb, no err; next clean frame 0x12 received correctly.
REQ-033 Filter build: frame 0x00 with single-cycle high glitch at each DATA sample point -> dat=0x00; non-filter build -> dat=0xFF.
